// File: rtl/sfu_pid_splitter.sv
// sfu_pid_splitter: holds one full-warp SFU request and emits it as
// NUM_LANES-wide packets tagged with pid/sop/eop, skipping all-inactive packets.
module sfu_pid_splitter #(
   parameter int unsigned THREAD_CNT = 8,
   parameter int unsigned NUM_LANES  = 2,
   parameter int unsigned XLEN       = 32,
   parameter int unsigned HDR_W      = 64,
   localparam int unsigned NUM_PKTS  = THREAD_CNT / NUM_LANES,
   localparam int unsigned PID_WIDTH = (NUM_PKTS > 1) ? $clog2(NUM_PKTS) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [HDR_W-1:0]              in_hdr,
   input  logic [THREAD_CNT-1:0]         in_tmask,
   input  logic [THREAD_CNT*XLEN-1:0]    in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [HDR_W-1:0]              out_hdr,
   output logic [NUM_LANES-1:0]          out_tmask,
   output logic [NUM_LANES*XLEN-1:0]     out_data,
   output logic [PID_WIDTH-1:0]          out_pid,
   output logic                          out_sop,
   output logic                          out_eop
);

   // holding register for one warp
   logic                       busy;
   logic [PID_WIDTH-1:0]       cur_pid;
   logic [PID_WIDTH-1:0]       first_pid_q;
   logic [HDR_W-1:0]           hdr_q;
   logic [THREAD_CNT-1:0]      tmask_q;
   logic [THREAD_CNT*XLEN-1:0] data_q;

   logic [NUM_PKTS-1:0]        held_act;
   logic [NUM_PKTS-1:0]        in_act;
   logic [PID_WIDTH-1:0]       in_first_pid;
   logic [PID_WIDTH-1:0]       next_pid;
   logic                       has_next;
   logic                       is_last;
   logic                       in_fire;
   logic                       out_fire;

   // per-packet activity of the held and incoming masks, first/next active pid
   always_comb begin
      held_act     = '0;
      in_act       = '0;
      in_first_pid = '0;
      next_pid     = cur_pid;
      has_next     = 1'b0;
      for (int p = 0; p < int'(NUM_PKTS); p++) begin
         held_act[p] = |tmask_q[p*NUM_LANES +: NUM_LANES];
         in_act[p]   = |in_tmask[p*NUM_LANES +: NUM_LANES];
      end
      // scan downward so the lowest qualifying pid wins
      for (int p = int'(NUM_PKTS) - 1; p >= 0; p--) begin
         if (in_act[p]) in_first_pid = PID_WIDTH'(p);
         if (held_act[p] && (PID_WIDTH'(p) > cur_pid)) begin
            next_pid = PID_WIDTH'(p);
            has_next = 1'b1;
         end
      end
   end

   assign is_last  = ~has_next;
   assign in_ready = ~busy | (out_ready & is_last);
   assign in_fire  = in_valid & in_ready;
   assign out_fire = busy & out_ready;

   // select the cur_pid slice of the held warp
   always_comb begin
      out_tmask = '0;
      out_data  = '0;
      for (int p = 0; p < int'(NUM_PKTS); p++) begin
         if (cur_pid == PID_WIDTH'(p)) begin
            out_tmask = tmask_q[p*NUM_LANES +: NUM_LANES];
            out_data  = data_q[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
         end
      end
   end

   assign out_valid = busy;
   assign out_hdr   = hdr_q;
   assign out_pid   = cur_pid;
   assign out_sop   = busy & (cur_pid == first_pid_q);
   assign out_eop   = busy & is_last;

   // load on accept, advance pid on packet fire, release on last packet
   always_ff @(posedge clk) begin
      if (reset) begin
         busy        <= 1'b0;
         cur_pid     <= '0;
         first_pid_q <= '0;
         tmask_q     <= '0;
         hdr_q       <= '0;
         data_q      <= '0;
      end else if (in_fire) begin
         busy        <= 1'b1;
         cur_pid     <= in_first_pid;
         first_pid_q <= in_first_pid;
         tmask_q     <= in_tmask;
         hdr_q       <= in_hdr;
         data_q      <= in_data;
      end else if (out_fire) begin
         if (is_last) busy    <= 1'b0;
         else         cur_pid <= next_pid;
      end
   end

`ifndef SYNTHESIS
   logic in_warp_q;

   // lanes must tile the warp exactly
   always @(posedge clk) begin
      assert (THREAD_CNT % NUM_LANES == 0) else $error("THREAD_CNT not a multiple of NUM_LANES");
   end

   // a stalled packet must not change
   assert property (@(posedge clk) disable iff (reset)
      (out_valid && !out_ready) |=> (out_valid && $stable({out_hdr, out_tmask, out_data, out_pid, out_sop, out_eop})))
      else $error("output changed while stalled");

   // exactly one sop opens and one eop closes each emitted warp
   always_ff @(posedge clk) begin
      if (reset) begin
         in_warp_q <= 1'b0;
      end else if (out_fire) begin
         assert (out_sop != in_warp_q) else $error("sop out of sequence");
         in_warp_q <= ~out_eop;
      end
   end
`endif

endmodule

// File: tb/tb_sfu_pid_splitter.sv
// tb_sfu_pid_splitter: directed plan plus random traffic, checked against a
// packet-queue reference model derived from the warp masks.
module tb_sfu_pid_splitter;

   localparam int unsigned THREAD_CNT = 8;
   localparam int unsigned NUM_LANES  = 2;
   localparam int unsigned XLEN       = 32;
   localparam int unsigned HDR_W      = 64;
   localparam int unsigned NUM_PKTS   = THREAD_CNT / NUM_LANES;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       in_valid;
   logic                       in_ready;
   logic [HDR_W-1:0]           in_hdr;
   logic [THREAD_CNT-1:0]      in_tmask;
   logic [THREAD_CNT*XLEN-1:0] in_data;
   logic                       out_valid;
   logic                       out_ready;
   logic [HDR_W-1:0]           out_hdr;
   logic [NUM_LANES-1:0]       out_tmask;
   logic [NUM_LANES*XLEN-1:0]  out_data;
   logic [1:0]                 out_pid;
   logic                       out_sop;
   logic                       out_eop;

   sfu_pid_splitter #(
      .THREAD_CNT(THREAD_CNT), .NUM_LANES(NUM_LANES), .XLEN(XLEN), .HDR_W(HDR_W)
   ) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_hdr(in_hdr),
      .in_tmask(in_tmask), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_hdr(out_hdr),
      .out_tmask(out_tmask), .out_data(out_data), .out_pid(out_pid),
      .out_sop(out_sop), .out_eop(out_eop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [HDR_W-1:0]          hdr;
      logic [NUM_LANES-1:0]      tm;
      logic [NUM_LANES*XLEN-1:0] dat;
      logic [1:0]                pid;
      logic                      sop;
      logic                      eop;
   } pkt_t;

   pkt_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   rnd_on = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // expected packet list of one warp: every packet with any active lane, in pid order
   function automatic void push_warp(input logic [HDR_W-1:0] h, input logic [THREAD_CNT-1:0] tm,
                                     input logic [THREAD_CNT*XLEN-1:0] d);
      pkt_t pk;
      bit   found = 1'b0;
      for (int p = 0; p < int'(NUM_PKTS); p++) begin
         if (tm[p*NUM_LANES +: NUM_LANES] != '0) begin
            pk.hdr = h;
            pk.tm  = tm[p*NUM_LANES +: NUM_LANES];
            pk.dat = d[p*NUM_LANES*XLEN +: NUM_LANES*XLEN];
            pk.pid = 2'(p);
            pk.sop = !found;
            pk.eop = 1'b0;
            exp_q.push_back(pk);
            found = 1'b1;
         end
      end
      if (!found) begin
         pk.hdr = h;
         pk.tm  = '0;
         pk.dat = d[NUM_LANES*XLEN-1:0];
         pk.pid = 2'd0;
         pk.sop = 1'b1;
         pk.eop = 1'b1;
         exp_q.push_back(pk);
      end else begin
         exp_q[exp_q.size()-1].eop = 1'b1;
      end
   endfunction

   // monitor: compare outputs with the model head, then apply this edge's fires
   always @(negedge clk) begin
      logic exp_ir;
      if (reset) begin
         exp_q.delete();
      end else begin
         chk("out_valid", 128'(out_valid), 128'(exp_q.size() != 0));
         if (exp_q.size() == 0) exp_ir = 1'b1;
         else                   exp_ir = out_ready && exp_q[0].eop;
         chk("in_ready", 128'(in_ready), 128'(exp_ir));
         if (out_valid && exp_q.size() != 0) begin
            chk("out_pid",   128'(out_pid),   128'(exp_q[0].pid));
            chk("out_tmask", 128'(out_tmask), 128'(exp_q[0].tm));
            chk("out_sop",   128'(out_sop),   128'(exp_q[0].sop));
            chk("out_eop",   128'(out_eop),   128'(exp_q[0].eop));
            chk("out_hdr",   128'(out_hdr),   128'(exp_q[0].hdr));
            if (exp_q[0].tm != '0)
               chk("out_data", 128'(out_data), 128'(exp_q[0].dat));
         end
         if (out_valid && out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         if (in_valid && in_ready) push_warp(in_hdr, in_tmask, in_data);
      end
   end

   function automatic logic [THREAD_CNT*XLEN-1:0] rnd_data();
      logic [THREAD_CNT*XLEN-1:0] d;
      for (int k = 0; k < int'(THREAD_CNT); k++) d[k*XLEN +: XLEN] = $urandom;
      return d;
   endfunction

   // present one warp and hold it until accepted
   task automatic send(input logic [HDR_W-1:0] h, input logic [THREAD_CNT-1:0] tm);
      bit ok = 1'b0;
      in_valid = 1'b1;
      in_hdr   = h;
      in_tmask = tm;
      in_data  = rnd_data();
      for (int c = 0; c < 200 && !ok; c++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (!ok) chk("send_timeout", 128'(0), 128'(1));
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_hdr    = '0;
      in_tmask  = '0;
      in_data   = '0;
      out_ready = 1'b1;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_out_pid", 128'(out_pid), 128'(0));
      chk("rst_out_sop", 128'(out_sop), 128'(0));
      chk("rst_out_eop", 128'(out_eop), 128'(0));
      @(posedge clk);
      #1;

      // full warp, single active packet, split mask, back-to-back, all-zero mask
      send(64'h1111_0000_0000_00ff, 8'hff); idle(5);
      send(64'h2222_0000_0000_0030, 8'h30); idle(2);
      send(64'h3333_0000_0000_0081, 8'h81); idle(3);
      send(64'h4444_0000_0000_00aa, 8'hff);
      send(64'h5555_0000_0000_00bb, 8'hff); idle(9);
      send(64'h6666_0000_0000_0000, 8'h00); idle(2);

      // stall pid1 for three cycles
      send(64'h7777_0000_0000_00ff, 8'hff);
      idle(1);
      out_ready = 1'b0;
      idle(3);
      out_ready = 1'b1;
      idle(4);

      // reset while pid1 is presented; warp must not resume
      send(64'h8888_0000_0000_00ff, 8'hff);
      idle(1);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      idle(5);

      // random traffic with random backpressure
      rnd_on = 1'b1;
      fork
         while (rnd_on) begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(3) != 0);
         end
      join_none
      for (int w = 0; w < 400; w++) begin
         logic [THREAD_CNT-1:0] tm;
         case ($urandom_range(3))
            0:       tm = '0;
            1:       tm = '1;
            default: tm = THREAD_CNT'($urandom & $urandom);
         endcase
         send({$urandom, $urandom}, tm);
         idle($urandom_range(2));
      end
      rnd_on = 1'b0;
      idle(1);
      out_ready = 1'b1;
      for (int c = 0; c < 100 && exp_q.size() != 0; c++) idle(1);
      chk("drain", 128'(exp_q.size()), 128'(0));
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
